// File: rtl/conv_requant_buffer_pkg.sv
// Shared definitions for the requantising layer buffers: FSM state encodings
// and the int32 -> int8 requantisation function.
package conv_requant_buffer_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int ACC_W = 32;
    localparam int PIX_W = 8;

    // Optional ReLU, round-half-up, arithmetic shift, then saturate to int8.
    // The 33-bit sum keeps the rounding add from overflowing near +2^31.
    function automatic logic signed [PIX_W-1:0] requantise(
        input logic signed [ACC_W-1:0] acc,
        input int                      shift,
        input logic                    relu
    );
        logic signed [ACC_W:0]   wide;
        logic signed [ACC_W:0]   rnd;
        logic signed [ACC_W:0]   shifted;
        logic signed [PIX_W-1:0] result;
        wide = {acc[ACC_W-1], acc};
        if (shift > 0) begin
            rnd = 33'sd1 <<< (shift - 1);
        end else begin
            rnd = 33'sd0;
        end
        shifted = (wide + rnd) >>> shift;
        if (relu && acc[ACC_W-1]) begin
            result = 8'sd0;
        end else if (shifted > 33'sd127) begin
            result = 8'sd127;
        end else if (shifted < -33'sd128) begin
            result = -8'sd128;
        end else begin
            result = shifted[PIX_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_requant_buffer_byte_buffer.sv
// Simple dual-port byte store: one synchronous write port and one read port
// whose data is registered and holds while rd_en is low.
module byte_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_requant_buffer.sv
// Collects a full requantised feature map, then streams it downstream as one
// gap-free burst once the consumer signals it is ready.
module conv_requant_buffer
    import conv_requant_buffer_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int CHANNEL    = 8,
    parameter int SHIFT      = 8,
    parameter int RELU       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        ds_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        overflow,
    output state_e      dbg_state
);

    localparam int SIZE  = IMG_WIDTH * IMG_HEIGHT * CHANNEL;
    localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             overflow_q, overflow_d;
    logic             rd_vld_q, rd_vld_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;

    logic             wr_en;
    logic             rd_en;
    logic [7:0]       wr_data;
    logic [7:0]       rd_data;

    assign wr_data = requantise(in_data, SHIFT, RELU != 0);

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST) begin
                        wr_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                if (ds_ready) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                // ds_ready is ignored here: once started, the burst never pauses.
                rd_en = 1'b1;
                if (rd_cnt_q == LAST) begin
                    rd_cnt_d = '0;
                    state_d  = S_FILL;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Read issue -> registered RAM data -> output register.
    always_comb begin
        rd_vld_d    = rd_en;
        out_valid_d = rd_vld_q;
        out_data_d  = out_data_q;
        if (rd_vld_q) begin
            out_data_d = rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            overflow_q  <= overflow_d;
            rd_vld_q    <= rd_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    byte_buffer #(
        .DEPTH (SIZE),
        .AW    (CNT_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt_q),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_FILL);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_requant_buffer.sv
// Directed bench: a frame-level model (queues of expected bytes) checked against
// two DUT configurations on every valid output cycle.
module tb_conv_requant_buffer;
    import conv_requant_buffer_pkg::*;

    localparam int SIZE  = 8 * 4 * 4;
    localparam int SIZE2 = 2;

    logic        clk;
    logic        rst;
    logic        in_valid, in_valid2;
    logic [31:0] in_data, in_data2;
    logic        ds_ready, ds_ready2;
    logic        out_valid, out_valid2;
    logic [7:0]  out_data, out_data2;
    logic        busy, busy2;
    logic        overflow, overflow2;
    state_e      dbg_state, dbg_state2;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  exp2_q[$];
    logic [7:0]  pend_q[$];
    logic [7:0]  log1 [0:511];
    logic [7:0]  log2 [0:7];
    int          log_n = 0;
    int          log2_n = 0;

    conv_requant_buffer #(
        .IMG_WIDTH(8), .IMG_HEIGHT(4), .CHANNEL(4), .SHIFT(8), .RELU(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .ds_ready(ds_ready), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .overflow(overflow), .dbg_state(dbg_state)
    );

    conv_requant_buffer #(
        .IMG_WIDTH(2), .IMG_HEIGHT(1), .CHANNEL(1), .SHIFT(8), .RELU(0)
    ) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
        .ds_ready(ds_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .busy(busy2), .overflow(overflow2), .dbg_state(dbg_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Integer reference: ReLU, add half LSB, floor-divide by 2^shift, clamp.
    function automatic logic [7:0] model_rq(input logic [31:0] raw, input int shift, input bit relu);
        longint v, d, q;
        v = longint'($signed(raw));
        d = longint'(1) << shift;
        if (relu && v < 0) return 8'h00;
        if (shift > 0) v = v + d / 2;
        q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every valid output must match the head of its model queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("dut1_unexpected_pixel", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("dut1_pixel", 32'(out_data), 32'(e));
            end
            if (log_n < 512) log1[log_n] = out_data;
            log_n++;
        end
        if (!rst && out_valid2) begin
            if (exp2_q.size() == 0) begin
                check("dut2_unexpected_pixel", 32'(exp2_q.size()), 32'd1);
            end else begin
                e = exp2_q.pop_front();
                check("dut2_pixel", 32'(out_data2), 32'(e));
            end
            if (log2_n < 8) log2[log2_n] = out_data2;
            log2_n++;
        end
    end

    // Driver: optional idle gap, then one accepted word; a full frame moves to exp_q.
    task automatic send_word(input logic [31:0] v, input int max_gap);
        repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = v;
        pend_q.push_back(model_rq(v, 8, 1'b1));
        if (pend_q.size() == SIZE) begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
            pend_q.delete();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n < 3000), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_cyc, run, n, c0;
        bit ended, busy_ok, out_seen;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; ds_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; ds_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_FILL));
        rst = 1'b0;

        // Hand-computed pins on the reference model.
        check("pin_0x180", 32'(model_rq(32'h0000_0180, 8, 1'b1)), 32'd2);
        check("pin_neg5_relu", 32'(model_rq(32'hFFFF_FFFB, 8, 1'b1)), 32'd0);
        check("pin_0x10000", 32'(model_rq(32'h0001_0000, 8, 1'b1)), 32'd127);
        check("pin_m300", 32'(model_rq(-32'sd300, 8, 1'b0)), 32'hFF);
        check("pin_min", 32'(model_rq(32'h8000_0000, 8, 1'b0)), 32'h80);

        // No-ReLU configuration: rounding toward -1 and negative saturation.
        @(posedge clk); #1;
        in_valid2 = 1'b1; in_data2 = -32'sd300;
        exp2_q.push_back(model_rq(-32'sd300, 8, 1'b0));
        @(posedge clk); #1;
        in_data2 = 32'h8000_0000;
        exp2_q.push_back(model_rq(32'h8000_0000, 8, 1'b0));
        @(posedge clk); #1;
        in_valid2 = 1'b0; ds_ready2 = 1'b1;
        n = 0;
        while ((exp2_q.size() != 0 || out_valid2) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ds_ready2 = 1'b0;
        check("dut2_drain_done", 32'(n < 50), 32'd1);
        check("dut2_count", 32'(log2_n), 32'(SIZE2));
        check("dut2_byte0", 32'(log2[0]), 32'hFF);
        check("dut2_byte1", 32'(log2[1]), 32'h80);

        // Frame A: rounding / ReLU / saturation values at the head of the frame.
        ds_ready = 1'b1;
        log_n = 0;
        send_word(32'h0000_0180, 2);
        send_word(32'hFFFF_FFFB, 2);
        send_word(32'h0001_0000, 2);
        for (int k = 3; k < SIZE; k++) send_word(32'(k) << 8, 2);
        wait_drained("frameA_drain");
        ds_ready = 1'b0;
        check("frameA_byte0", 32'(log1[0]), 32'd2);
        check("frameA_byte1", 32'(log1[1]), 32'd0);
        check("frameA_byte2", 32'(log1[2]), 32'd127);
        check("frameA_count", 32'(log_n), 32'(SIZE));

        // Frame B: k mod 128 pattern, held in S_WAIT for 50 cycles with a dropped word.
        for (int k = 0; k < SIZE; k++) send_word(32'(k % 128) << 8, 3);
        busy_ok = 1'b1; out_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin in_valid = 1'b1; in_data = 32'h7FFF_FFFF; end
            busy_ok &= busy;
            out_seen |= out_valid;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        check("wait_busy", 32'(busy_ok), 32'd1);
        check("wait_no_output", 32'(out_seen), 32'd0);
        check("overflow_in_wait", 32'(overflow), 32'd1);
        log_n = 0;
        c0 = cyc;
        ds_ready = 1'b1;
        first_cyc = -1; run = 0; n = 0; ended = 1'b0;
        while (n < 400 && !ended) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    ds_ready = 1'b0;
                    in_valid = 1'b1;
                    in_data = 32'h0000_0100;
                end else begin
                    in_valid = 1'b0;
                end
                run++;
            end else if (first_cyc >= 0) begin
                ended = 1'b1;
            end
        end
        in_valid = 1'b0;
        check("drain_latency", 32'(first_cyc), 32'(c0 + 3));
        check("drain_burst_len", 32'(run), 32'(SIZE));
        check("drain_all_consumed", 32'(exp_q.size()), 32'd0);
        check("frameB_byte5", 32'(log1[5]), 32'd5);
        check("frameB_byte127", 32'(log1[127]), 32'd127);
        check("out_data_hold", 32'(out_data), 32'd127);
        check("overflow_sticky", 32'(overflow), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a frame, then a fresh frame.
        ds_ready = 1'b1;
        for (int k = 0; k < 100; k++) send_word(32'(k + 50) << 8, 1);
        rst = 1'b1;
        pend_q.delete();
        @(posedge clk); #1;
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        log_n = 0;
        for (int k = 0; k < SIZE; k++)
            send_word(32'(((k * 3 + 90) % 200) - 60) * 32'd256 + 32'((k % 7) * 40), 2);
        wait_drained("frameC_drain");
        check("frameC_first_pixel", 32'(log1[0]), 32'd30);
        check("frameC_overflow", 32'(overflow), 32'd0);

        // Two frames back to back; the second starts the cycle busy falls.
        log_n = 0;
        for (int k = 0; k < SIZE; k++) send_word(32'((k ^ 32'h55) & 32'h7F) << 8, 0);
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_busy_falls", 32'(n < 1000), 32'd1);
        for (int k = 0; k < SIZE; k++) send_word(32'(127 - k) << 8, 0);
        wait_drained("b2b_drain");
        check("b2b_count", 32'(log_n), 32'(2 * SIZE));
        check("b2b_second_first", 32'(log1[SIZE]), 32'd127);
        check("b2b_overflow", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
